// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : mdu_controller
// Brief    : E-stage multiply/divide sequencer owning HI/LO; MDU_MADD_EN adds
//            MADD/MADDU accumulate ops.
// Revision : 1.0  initial release
// ============================================================================

module mdu_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
`endif

    localparam logic [3:0] c_mult_n = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_n  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_pend_hi, w_pend_hi_nxt;
    logic [31:0] r_pend_lo, w_pend_lo_nxt;
    logic        r_pend_wr, w_pend_wr_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    // Product: sign-extend to 64 bits for signed ops; low 64 bits are exact.
    logic        w_mul_signed;
    logic [63:0] w_mul_a, w_mul_b, w_prod;

`ifdef MDU_MADD_EN
    assign w_mul_signed = (op == c_op_mult) || (op == c_op_madd);
`else
    assign w_mul_signed = (op == c_op_mult);
`endif
    assign w_mul_a = w_mul_signed ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
    assign w_mul_b = w_mul_signed ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {r_hi, r_lo} + w_prod;
`endif

    // Division on magnitudes so INT_MIN / -1 wraps cleanly to 0x80000000.
    logic        w_div_signed, w_div_zero, w_a_neg, w_b_neg;
    logic [31:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_div_signed = (op == c_op_div);
    assign w_div_zero   = (rt_data == 32'd0);
    assign w_a_neg      = w_div_signed & rs_data[31];
    assign w_b_neg      = w_div_signed & rt_data[31];
    assign w_abs_a      = w_a_neg ? -rs_data : rs_data;
    assign w_abs_b      = w_div_zero ? 32'd1 : (w_b_neg ? -rt_data : rt_data);
    assign w_q_mag      = w_abs_a / w_abs_b;
    assign w_r_mag      = w_abs_a % w_abs_b;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem        = w_a_neg ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;

        case (r_state)
            IDLE: begin
                if (start) begin
                    case (op)
                        c_op_mult, c_op_multu: begin
                            w_state_nxt   = BUSY;
                            w_cnt_nxt     = c_mult_n;
                            w_pend_hi_nxt = w_prod[63:32];
                            w_pend_lo_nxt = w_prod[31:0];
                            w_pend_wr_nxt = 1'b1;
                        end
                        c_op_div, c_op_divu: begin
                            w_state_nxt   = BUSY;
                            w_cnt_nxt     = c_div_n;
                            w_pend_hi_nxt = w_rem;
                            w_pend_lo_nxt = w_quot;
                            w_pend_wr_nxt = !w_div_zero;
                        end
`ifdef MDU_MADD_EN
                        c_op_madd, c_op_maddu: begin
                            w_state_nxt   = BUSY;
                            w_cnt_nxt     = c_mult_n;
                            w_pend_hi_nxt = w_acc[63:32];
                            w_pend_lo_nxt = w_acc[31:0];
                            w_pend_wr_nxt = 1'b1;
                        end
`endif
                        c_op_mthi: w_hi_nxt = rs_data;
                        c_op_mtlo: w_lo_nxt = rs_data;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Requests arriving while busy are dropped by design.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = IDLE;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state == BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_controller
// Brief    : Directed self-checking bench for mdu_controller.
// Revision : 1.0  initial release
// ============================================================================

module tb_mdu_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_controller #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe one request through a rising edge; returns at the following negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 4'd0;
    endtask

    task automatic busy_for(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_end"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_hl(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 4'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_hl("rst", 32'd0, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        busy_for("mult_busy", 5);
        chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        issue(4'd4, 32'd100, 32'd7);
        busy_for("divu_busy", 10);
        chk_hl("divu", 32'd2, 32'd14);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        busy_for("div_busy", 10);
        chk_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_for("divovf_busy", 10);
        chk_hl("div_ovf", 32'd0, 32'h8000_0000);

        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_for("multu_busy", 5);
        chk_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(4'd5, 32'h1234_5678, 32'd0);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk_hl("mthi", 32'h1234_5678, 32'h0000_0001);

        issue(4'd6, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk_hl("mtlo", 32'h1234_5678, 32'hCAFE_F00D);

        issue(4'd3, 32'd55, 32'd0);
        busy_for("div0_busy", 10);
        chk_hl("div0", 32'h1234_5678, 32'hCAFE_F00D);

        issue(4'd0, 32'd9, 32'd9);
        issue(4'd15, 32'd9, 32'd9);
        chk("nop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk_hl("nop", 32'h1234_5678, 32'hCAFE_F00D);

        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        issue(4'd7, 32'hFFFF_FFFE, 32'd3);
`ifdef MDU_MADD_EN
        busy_for("madd_busy", 5);
        chk_hl("madd", 32'd0, 32'd4);
`else
        chk("madd_off_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("madd_off_busy2", 32'(busy), 32'd0);
        chk_hl("madd_off", 32'd0, 32'd10);
`endif

        // Request during busy must not disturb the running divide.
        issue(4'd3, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) begin
            chk("ign_busy_a", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("ign_busy_b", 32'(busy), 32'd1);
        issue(4'd2, 32'd2, 32'd3);
        busy_for("ign_busy_c", 6);
        chk_hl("ign", 32'd2, 32'd14);
        repeat (6) @(negedge clk);
        chk_hl("ign_after", 32'd2, 32'd14);

        issue(4'd1, 32'd2, 32'd3);
        chk("abort_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("abort_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk_hl("abort", 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_later_busy", 32'(busy), 32'd0);
        chk_hl("abort_later", 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
